// File: rtl/key_char_fifo.sv
// Keyboard character queue: toggle-strobe capture into a first-word-fall-through FIFO
// with sticky overflow and a registered level interrupt.
module key_char_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          iClock,
    input  logic          iReset,
    input  logic [7:0]    iKey_ascii,
    input  logic          iKey_stroke,
    input  logic          iRead,
    input  logic          iClr_ovf,
    input  logic          iIrq_en,
    output logic [7:0]    oData,
    output logic          oEmpty,
    output logic          oFull,
    output logic [AW:0]   oCount,
    output logic          oOverflow,
    output logic          oIrq
);

    localparam logic [AW:0] ONE     = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_empty;
    logic          r_full;
    logic          r_ovf;
    logic          r_irq;
    logic          r_stroke_d;
    logic          r_primed;

    logic          w_push_req;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [AW:0]   w_count_nxt;

    // The first post-reset edge only samples the stroke level, so a stale
    // level never shows up as a phantom character.
    assign w_push_req = r_primed & (iKey_stroke ^ r_stroke_d);
    assign w_pop      = iRead & ~r_empty;
    assign w_push     = w_push_req & (~r_full | w_pop);
    assign w_drop     = w_push_req & r_full & ~w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - ONE;
        end
    end

    always_ff @(posedge iClock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= iKey_ascii;
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_ovf      <= 1'b0;
            r_irq      <= 1'b0;
            r_stroke_d <= 1'b0;
            r_primed   <= 1'b0;
        end else begin
            r_stroke_d <= iKey_stroke;
            r_primed   <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == DEPTH_C);
            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (iClr_ovf) begin
                r_ovf <= 1'b0;
            end
            r_irq <= iIrq_en & (w_count_nxt != '0);
        end
    end

    assign oData     = r_mem[r_rd_ptr];
    assign oEmpty    = r_empty;
    assign oFull     = r_full;
    assign oCount    = r_count;
    assign oOverflow = r_ovf;
    assign oIrq      = r_irq;

endmodule

// File: tb/tb_key_char_fifo.sv
// Scoreboard bench for key_char_fifo: stimulus queues expected characters,
// a negedge monitor checks every pop against the queue head.
module tb_key_char_fifo;

    logic       iClock = 1'b0;
    logic       iReset;
    logic [7:0] iKey_ascii;
    logic       iKey_stroke;
    logic       iRead;
    logic       iClr_ovf;
    logic       iIrq_en;
    logic [7:0] oData;
    logic       oEmpty;
    logic       oFull;
    logic [4:0] oCount;
    logic       oOverflow;
    logic       oIrq;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    key_char_fifo #(.DEPTH(16), .AW(4)) dut (
        .iClock     (iClock),
        .iReset     (iReset),
        .iKey_ascii (iKey_ascii),
        .iKey_stroke(iKey_stroke),
        .iRead      (iRead),
        .iClr_ovf   (iClr_ovf),
        .iIrq_en    (iIrq_en),
        .oData      (oData),
        .oEmpty     (oEmpty),
        .oFull      (oFull),
        .oCount     (oCount),
        .oOverflow  (oOverflow),
        .oIrq       (oIrq)
    );

    always #5 iClock = ~iClock;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a pop happens at the next rising edge whenever iRead is
    // high and the queue is non-empty; the head must match the scoreboard.
    always @(negedge iClock) begin
        if (!iReset && iRead && !oEmpty) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %0h expected none", oData);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (oData !== e) begin
                    n_fail++;
                    $display("FAIL pop_data: got %0h expected %0h", oData, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic push(input logic [7:0] c, input bit accepted);
        iKey_ascii  = c;
        iKey_stroke = ~iKey_stroke;
        if (accepted) exp_q.push_back(c);
        tick();
    endtask

    task automatic pop_n(input int n);
        iRead = 1'b1;
        repeat (n) tick();
        iRead = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        iReset = 1'b1;
        iKey_ascii = 8'h00;
        iKey_stroke = 1'b1;
        iRead = 1'b0;
        iClr_ovf = 1'b0;
        iIrq_en = 1'b0;
        repeat (2) tick();
        chk("rst_count", oCount, 0);
        chk("rst_empty", oEmpty, 1);
        chk("rst_full", oFull, 0);
        chk("rst_ovf", oOverflow, 0);
        chk("rst_irq", oIrq, 0);

        // Stale high stroke level across reset release.
        iReset = 1'b0;
        repeat (10) tick();
        chk("phantom_empty", oEmpty, 1);
        chk("phantom_count", oCount, 0);

        push(8'h41, 1);
        chk("lat_empty", oEmpty, 0);
        chk("lat_data", oData, 8'h41);
        push(8'h42, 1);
        push(8'h43, 1);
        chk("abc_count", oCount, 3);
        pop_n(3);
        chk("abc_empty", oEmpty, 1);
        chk("abc_count0", oCount, 0);

        iIrq_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(8'(i), 1);
            if (i == 0) chk("irq_first", oIrq, 1);
        end
        chk("full_flag", oFull, 1);
        chk("full_count", oCount, 16);
        chk("full_ovf0", oOverflow, 0);
        push(8'h55, 0);
        chk("drop_ovf", oOverflow, 1);
        chk("drop_count", oCount, 16);

        iRead = 1'b1;
        push(8'h60, 1);
        iRead = 1'b0;
        chk("fullrw_count", oCount, 16);
        chk("fullrw_full", oFull, 1);

        iClr_ovf = 1'b1;
        tick();
        iClr_ovf = 1'b0;
        chk("clr_ovf", oOverflow, 0);
        pop_n(16);
        chk("drain_empty", oEmpty, 1);
        chk("drain_irq", oIrq, 0);

        // Push plus read while empty: only the push takes effect.
        iRead = 1'b1;
        push(8'h7a, 1);
        iRead = 1'b0;
        chk("empty_rw_count", oCount, 1);
        chk("empty_rw_data", oData, 8'h7a);
        for (int i = 0; i < 15; i++) push(8'h90 + 8'(i), 1);
        chk("refill_full", oFull, 1);
        iClr_ovf = 1'b1;
        push(8'hee, 0);
        iClr_ovf = 1'b0;
        chk("set_wins", oOverflow, 1);
        pop_n(16);
        chk("drain2_count", oCount, 0);
        iClr_ovf = 1'b1;
        tick();
        iClr_ovf = 1'b0;

        for (int i = 0; i < 20; i++) begin
            push(8'h80 + 8'(i), 1);
            pop_n(1);
        end
        chk("wrap_empty", oEmpty, 1);
        chk("sb_empty", exp_q.size(), 0);

        push(8'hc1, 1);
        push(8'hc2, 1);
        push(8'hc3, 1);
        chk("pre_rst_count", oCount, 3);
        #2;
        iReset = 1'b1;
        #1;
        exp_q.delete();
        chk("async_count", oCount, 0);
        chk("async_empty", oEmpty, 1);
        chk("async_irq", oIrq, 0);
        tick();
        // Toggle landing on the priming edge must be lost.
        iReset = 1'b0;
        iKey_stroke = ~iKey_stroke;
        repeat (3) tick();
        chk("post_rst_count", oCount, 0);
        chk("post_rst_empty", oEmpty, 1);
        chk("post_rst_irq", oIrq, 0);

        push(8'hd5, 1);
        chk("post_rst_push", oCount, 1);
        pop_n(1);
        chk("final_sb", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/key_char_fifo.md
KEY_CHAR_FIFO -- requirements
Module: key_char_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, number of character entries (power of two, 2..256).
REQ-002 The block SHALL have parameter AW, default 4, pointer width equal to log2(DEPTH).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports in this order: iClock input 1 (rising-edge system clock), then iReset input 1 (asynchronous, active-high reset).
REQ-004 The block SHALL have port iKey_ascii, input, 8 bits: character code from the keyboard decoder, stable whenever iKey_stroke toggles.
REQ-005 The block SHALL have port iKey_stroke, input, 1 bit: toggle from the decoder; each level change marks one new character. It is in the iClock domain.
REQ-006 The block SHALL have port iRead, input, 1 bit: single-cycle pop strobe from the CPU bus.
REQ-007 The block SHALL have port iClr_ovf, input, 1 bit: clears the sticky overflow flag.
REQ-008 The block SHALL have port iIrq_en, input, 1 bit: interrupt enable.
REQ-009 The block SHALL have port oData, output, 8 bits: head-of-queue character (first-word-fall-through).
REQ-010 The block SHALL have port oEmpty, output, 1 bit: the queue holds no characters.
REQ-011 The block SHALL have port oFull, output, 1 bit: the queue holds DEPTH characters.
REQ-012 The block SHALL have port oCount, output, AW+1 bits: current occupancy, 0..DEPTH.
REQ-013 The block SHALL have port oOverflow, output, 1 bit: sticky flag, set when a character was dropped.
REQ-014 The block SHALL have port oIrq, output, 1 bit: registered level interrupt.

Function
REQ-015 The block SHALL hold stroke_d, a registered copy of iKey_stroke, and a primed flag.
- On the first clock after reset release, stroke_d SHALL load iKey_stroke, primed SHALL set, and no push SHALL occur.
REQ-016 Once primed=1, a push request SHALL be generated in any cycle where iKey_stroke differs from stroke_d; stroke_d SHALL update every cycle.
REQ-017 On an accepted push, iKey_ascii SHALL be written to mem[wr_ptr] at that clock edge, and wr_ptr SHALL increment modulo DEPTH.
REQ-018 A pop request SHALL be iRead=1 while oEmpty=0.
- On a pop, rd_ptr SHALL increment modulo DEPTH.
- iRead while oEmpty=1 SHALL be ignored, with no pointer or count change.
REQ-019 oData SHALL equal mem[rd_ptr] combinationally; oData is valid only when oEmpty=0.
REQ-020 oCount, oEmpty and oFull SHALL be registered and updated at the same edge as the pointers.
- Push only: count+1.
- Pop only: count-1.
- Push and pop together: count unchanged.
REQ-021 A push while oFull=1 SHALL be accepted only if a pop occurs in the same cycle.
- In that case the count stays DEPTH.
- Otherwise the character SHALL be dropped, the pointers SHALL be unchanged, and oOverflow SHALL set at that edge.
REQ-022 A push and a pop together while oEmpty=1 SHALL perform the push only; the pop is ignored and the count becomes 1.
REQ-023 Latency: a stroke toggle visible at edge N SHALL produce oEmpty=0, updated oCount and valid oData after edge N (push-to-read latency of 1 cycle).
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0 with no loss of data or flags.
REQ-025 oOverflow SHALL clear on iClr_ovf=1.
- If iClr_ovf and a dropped push coincide, set SHALL win and oOverflow SHALL remain 1.
REQ-026 oIrq SHALL be registered as iIrq_en AND (the next-state count being non-zero), so it asserts in the same cycle as oEmpty deasserts.
REQ-027 Memory contents SHALL NOT require reset; only pointers, count, flags, stroke_d and primed are reset.

Reset
REQ-028 While iReset=1, the following SHALL hold immediately (asynchronously):
- wr_ptr=0, rd_ptr=0.
- oCount=0, oEmpty=1, oFull=0.
- oOverflow=0, oIrq=0.
- stroke_d=0, primed=0.
REQ-029 A reset asserted mid-operation SHALL discard all queued characters.
- The first post-reset cycle SHALL perform priming only, per REQ-015, so a stale stroke level never creates a phantom character.
REQ-030 A stroke toggle that occurs in the priming cycle SHALL be lost.

Verification
REQ-031 Reset with iKey_stroke=1, then hold it constant for 10 cycles -> oEmpty stays 1, oCount=0 (no phantom push).
REQ-032 Toggle stroke with ascii 0x41, 0x42, 0x43 on separate cycles, then pop three times -> oData reads 0x41, 0x42, 0x43 in order, then oEmpty=1 and oCount=0.
REQ-033 With iIrq_en=1, push 16 chars (0x00..0x0F) then a 17th (0x55) -> oFull=1, oCount=16, oOverflow=1; pops return 0x00..0x0F and 0x55 never appears.
REQ-034 When full, push 0x60 in the same cycle as iRead -> oCount stays 16, and the last pop returns 0x60.
REQ-035 Hold oCount=0, then toggle stroke and assert iRead in the same cycle -> oCount=1, oData=pushed char; assert iClr_ovf during an overflowing push -> oOverflow stays 1.
REQ-036 Push 20 and pop 20 interleaved, crossing pointer wrap, then pulse iReset with 3 chars queued -> data order is preserved, and after reset oCount=0, oEmpty=1, oIrq=0.
